// File: rtl/axis_ddr3_writer_pkg.sv
`default_nettype none
// ============================================================================
// Package   : axis_ddr3_writer_pkg
// Purpose   : Shared AXI encodings and writer FSM state type for the
//             axis_ddr3_writer stream-to-AXI burst packer.
// Revision  : 1.0 - initial release
// ============================================================================
package axis_ddr3_writer_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SEND  = 2'd2,
        ST_DRAIN = 2'd3
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_ddr3_writer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module    : sync_fifo
// Purpose   : Single-clock first-word-fall-through FIFO. rd_data_o always
//             shows the head entry while empty_o is low. DEPTH must be a
//             power of two.
// Revision  : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_wr;
    logic          do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[PW-1:0]];

    // Next-state for storage and pointers; overflow/underflow requests are dropped.
    always_comb begin
        do_wr    = wr_en_i & ~full_o;
        do_rd    = rd_en_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[PW-1:0]] = wr_data_i;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; only the pointers are flushed.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_ddr3_writer.sv
`default_nettype none
// ============================================================================
// Module    : axis_ddr3_writer
// Purpose   : Packs a valid/ready/last 32-bit stream into AXI4 INCR write
//             bursts of up to MAX_BEATS beats, issues them to the DDR3
//             controller's AW/W ports, tracks B responses and reports
//             completion and any error response.
// Revision  : 1.0 - initial release
// ============================================================================
module axis_ddr3_writer
    import axis_ddr3_writer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDRS     = 27,
    parameter int REQID     = 4,
    parameter int WR_ID     = 0,
    parameter int MAX_BEATS = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic               clock,
    input  logic               reset,
    // control
    input  logic               cfg_start_i,
    input  logic [ADDRS-1:0]   cfg_addr_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    // stream in
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic               s_last_i,
    input  logic [WIDTH-1:0]   s_data_i,
    // AXI write address
    output logic               axi_awvalid_o,
    input  logic               axi_awready_i,
    output logic [ADDRS-1:0]   axi_awaddr_o,
    output logic [REQID-1:0]   axi_awid_o,
    output logic [7:0]         axi_awlen_o,
    output logic [1:0]         axi_awburst_o,
    // AXI write data
    output logic               axi_wvalid_o,
    input  logic               axi_wready_i,
    output logic               axi_wlast_o,
    output logic [WIDTH/8-1:0] axi_wstrb_o,
    output logic [WIDTH-1:0]   axi_wdata_o,
    // AXI write response
    input  logic               axi_bvalid_i,
    output logic               axi_bready_o,
    input  logic [1:0]         axi_bresp_i,
    input  logic [REQID-1:0]   axi_bid_i
);

    localparam int BCW        = $clog2(MAX_BEATS + 1);
    localparam int OCW        = $clog2(MAX_OUTST + 1);
    localparam int LQ_DEPTH   = MAX_OUTST + 1;
    localparam int LQ_PW      = $clog2(LQ_DEPTH);
    localparam int LQ_SLOTS   = 1 << LQ_PW;
    localparam int FIFO_DEPTH = 2 * MAX_BEATS;
    localparam int BYTE_SH    = $clog2(WIDTH / 8);

    localparam logic [BCW-1:0]   BEATS_FULL = BCW'(MAX_BEATS);
    localparam logic [BCW-1:0]   ONE_BEAT   = BCW'(1);
    localparam logic [OCW-1:0]   OUTST_MAX  = OCW'(MAX_OUTST);
    localparam logic [LQ_PW-1:0] LQ_LAST    = LQ_PW'(LQ_DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_t         state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              last_seen_q, last_seen_d;
    logic [ADDRS-1:0]  addr_q, addr_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [OCW-1:0]    outst_q, outst_d;

    // Length queue: one entry per cut burst (beat count + holds-s_last flag).
    // Storage is rounded up to a power of two; pointers wrap at LQ_DEPTH.
    logic [BCW-1:0]    lq_len_q [LQ_SLOTS];
    logic [BCW-1:0]    lq_len_d [LQ_SLOTS];
    logic [LQ_SLOTS-1:0] lq_last_q, lq_last_d;
    logic [LQ_PW-1:0]  lq_wr_q, lq_wr_d;
    logic [LQ_PW-1:0]  lq_rd_q, lq_rd_d;
    logic [LQ_PW:0]    lq_cnt_q, lq_cnt_d;

    // AXI output registers and per-burst progress.
    logic              awvalid_q, awvalid_d;
    logic [ADDRS-1:0]  awaddr_q, awaddr_d;
    logic [7:0]        awlen_q, awlen_d;
    logic              wvalid_q, wvalid_d;
    logic              wlast_q, wlast_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              bready_q, bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [BCW-1:0]    w_cnt_q, w_cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              start_accept;
    logic              beat_wr;
    logic              cut_push;
    logic [BCW-1:0]    cut_len;
    logic              lq_pop;
    logic              burst_done;
    logic              aw_hs, w_hs, b_hs, b_take;
    logic [BCW-1:0]    head_len;
    logic              head_last;
    logic              fifo_rd_en;
    logic              fifo_full, fifo_empty;
    logic [WIDTH:0]    fifo_rd_data;
    logic              unused_inputs;

    assign start_accept = (state_q == ST_IDLE) & cfg_start_i;
    assign s_ready_o    = busy_q & ~fifo_full & ~last_seen_q;
    assign beat_wr      = s_valid_i & s_ready_o;
    assign head_len     = lq_len_q[lq_rd_q];
    assign head_last    = lq_last_q[lq_rd_q];
    assign aw_hs        = awvalid_q & axi_awready_i;
    assign w_hs         = wvalid_q & axi_wready_i;
    assign b_hs         = axi_bvalid_i & bready_q;
    // A response with nothing outstanding (left over from before a reset) is dropped.
    assign b_take       = b_hs & (outst_q != '0);
    assign unused_inputs = ^{axi_bid_i, cfg_addr_i[3:0]};

    // Beat data and its last flag travel together through the FWFT FIFO.
    sync_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (beat_wr),
        .wr_data_i ({s_last_i, s_data_i}),
        .rd_en_i   (fifo_rd_en),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Burst cutting: count accepted beats and cut at MAX_BEATS or at s_last.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        last_seen_d = last_seen_q;
        cut_push    = 1'b0;
        cut_len     = beat_cnt_q + ONE_BEAT;
        if (start_accept) begin
            beat_cnt_d  = '0;
            last_seen_d = 1'b0;
        end else if (beat_wr) begin
            if (s_last_i || (cut_len == BEATS_FULL)) begin
                cut_push   = 1'b1;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = cut_len;
            end
            if (s_last_i) begin
                last_seen_d = 1'b1;
            end
        end
    end

    // Length queue push on a cut, pop when a burst completes on AXI.
    always_comb begin
        lq_len_d  = lq_len_q;
        lq_last_d = lq_last_q;
        lq_wr_d   = lq_wr_q;
        lq_rd_d   = lq_rd_q;
        lq_cnt_d  = lq_cnt_q;
        if (cut_push) begin
            lq_len_d[lq_wr_q]  = cut_len;
            lq_last_d[lq_wr_q] = s_last_i;
            lq_wr_d            = (lq_wr_q == LQ_LAST) ? '0 : lq_wr_q + 1'b1;
        end
        if (lq_pop) begin
            lq_rd_d = (lq_rd_q == LQ_LAST) ? '0 : lq_rd_q + 1'b1;
        end
        case ({cut_push, lq_pop})
            2'b10:   lq_cnt_d = lq_cnt_q + 1'b1;
            2'b01:   lq_cnt_d = lq_cnt_q - 1'b1;
            default: lq_cnt_d = lq_cnt_q;
        endcase
    end

    // Writer FSM: next state, AXI channel registers, address and outstanding count.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        error_d    = error_q;
        addr_d     = addr_q;
        outst_d    = outst_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        wdata_d    = wdata_q;
        bready_d   = 1'b1;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        w_cnt_d    = w_cnt_q;
        lq_pop     = 1'b0;
        fifo_rd_en = 1'b0;
        burst_done = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    state_d = ST_FILL;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    addr_d  = {cfg_addr_i[ADDRS-1:4], 4'h0};
                end
            end
            ST_FILL: begin
                // A queued length means all of that burst's beats are already buffered.
                if ((lq_cnt_q != '0) && !fifo_empty && (outst_q < OUTST_MAX)) begin
                    state_d    = ST_SEND;
                    awvalid_d  = 1'b1;
                    awaddr_d   = addr_q;
                    awlen_d    = 8'(head_len) - 8'd1;
                    wvalid_d   = 1'b1;
                    wdata_d    = fifo_rd_data[WIDTH-1:0];
                    wlast_d    = fifo_rd_data[WIDTH] | (head_len == ONE_BEAT);
                    fifo_rd_en = 1'b1;
                    w_cnt_d    = ONE_BEAT;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            ST_SEND: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        wdata_d    = fifo_rd_data[WIDTH-1:0];
                        wlast_d    = fifo_rd_data[WIDTH] | ((w_cnt_q + ONE_BEAT) == head_len);
                        w_cnt_d    = w_cnt_q + ONE_BEAT;
                        fifo_rd_en = 1'b1;
                    end
                end
                if ((aw_done_q | aw_hs) && (w_done_q | (w_hs & wlast_q))) begin
                    burst_done = 1'b1;
                    lq_pop     = 1'b1;
                    addr_d     = addr_q + (ADDRS'(head_len) << BYTE_SH);
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = head_last ? ST_DRAIN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (burst_done && !b_take) begin
            outst_d = outst_q + 1'b1;
        end else if (!burst_done && b_take) begin
            outst_d = outst_q - 1'b1;
        end

        if (b_hs && busy_q && (axi_bresp_i != AXI_RESP_OKAY)) begin
            error_d = 1'b1;
        end

        // Registered done lands in the cycle DRAIN sees zero outstanding,
        // so busy falls one cycle after the pulse.
        done_d = (state_d == ST_DRAIN) && (outst_d == '0);
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            last_seen_q <= 1'b0;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            outst_q     <= '0;
            lq_len_q    <= '{default: '0};
            lq_last_q   <= '0;
            lq_wr_q     <= '0;
            lq_rd_q     <= '0;
            lq_cnt_q    <= '0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_q     <= '0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            w_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            last_seen_q <= last_seen_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            outst_q     <= outst_d;
            lq_len_q    <= lq_len_d;
            lq_last_q   <= lq_last_d;
            lq_wr_q     <= lq_wr_d;
            lq_rd_q     <= lq_rd_d;
            lq_cnt_q    <= lq_cnt_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            w_cnt_q     <= w_cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = awaddr_q;
    assign axi_awid_o    = REQID'(WR_ID);
    assign axi_awlen_o   = awlen_q;
    assign axi_awburst_o = AXI_BURST_INCR;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wlast_o   = wlast_q;
    assign axi_wstrb_o   = '1;
    assign axi_wdata_o   = wdata_q;
    assign axi_bready_o  = bready_q;

endmodule
`default_nettype wire
